display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Parametrised multiplexed 7-segment/LED-matrix scanner; successor to the fixed 8-digit, one-digit-per-clock scanner.
- Time-multiplexes a DIGITS×SEG_W frame onto shared segment lines with one-hot common drive.
- Adds a slot prescaler, anti-ghost blanking, PWM brightness, per-digit enable, configurable drive polarity and a tear-free double-buffered frame load.
- Sits between the game graphics logic and the board LED pins; any segment remap/encoder stays downstream.

Parameters:
- DIGITS, 8: number of common lines / digits scanned.
- SEG_W, 8: segment bits per digit.
- DIV, 16: clk cycles per digit slot; must be ≥ BLANK_CYC+1.
- BLANK_CYC, 2: cycles at start of each slot with all commons and segments inactive.
- BRIGHT_W, 3: brightness code width.
- COM_ACTIVE_LOW, 1: 1 = selected common driven 0.
- SEG_ACTIVE_LOW, 0: 1 = lit segment driven 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_data  in  DIGITS*SEG_W  new frame; digit 0 = most-significant SEG_W slice
- frame_valid  in  1  frame_data offered
- frame_ready  out  1  pending buffer free; a transfer occurs when valid&&ready
- digit_en  in  DIGITS  per-digit enable, bit i = digit i
- brightness  in  BRIGHT_W  0 = dimmest, all-ones = full
- com  out  DIGITS  common drive; digit i uses bit DIGITS-1-i
- seg  out  SEG_W  segment drive
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot, aligned with com/seg
- digit_idx  out  clog2(DIGITS)  digit currently owning the slot, aligned with com/seg

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - slot_cnt=0, digit=0, pending empty, display buffer all zeros.
  - frame_ready=1, frame_start=0, digit_idx=0.
  - com all inactive (all 1s if COM_ACTIVE_LOW), seg all inactive.
  - Reset mid-scan aborts the slot immediately; no partial frame survives.
- Slot counter: slot_cnt counts 0..DIV-1, then wraps to 0 and increments digit.
- Digit wrap: digit DIGITS-1 wraps to 0. DIGITS need not be a power of two.
- On-time:
  - on_len = floor((DIV-BLANK_CYC)*(brightness+1) / 2^BRIGHT_W).
  - brightness and digit_en are sampled at slot_cnt==0 and held for the whole slot.
- Drive (internal, one cycle ahead of the pins): a digit is lit when slot_cnt ≥ BLANK_CYC, (slot_cnt-BLANK_CYC) < on_len, and digit_en[digit] was sampled 1.
  - When lit: the digit's common is active and seg = its buffer slice, polarity-adjusted.
  - Otherwise: all commons inactive and seg inactive.
  - on_len=0 means the digit stays dark for the whole slot.
- Latency: com, seg, frame_start and digit_idx are all registered, 1 cycle after the counter state.
- Disabled digits still consume their full slot, so frame period = DIGITS*DIV cycles regardless of enables.
- Frame load:
  - Transfer when frame_valid&&frame_ready: data goes to pending, frame_ready drops.
  - On the last cycle of the frame (digit=DIGITS-1, slot_cnt=DIV-1), pending is copied to the display buffer and frame_ready rises on the next cycle.
  - A transfer on that same last cycle goes to pending and is not displayed until the following frame boundary.
  - The display buffer never changes mid-frame (no tearing).
- At most one common is active in any cycle. Commons are never active during the blanking cycles.

Decomposition:
- Shared package display_pkg holds:
  - polarity helper constants COM_OFF/SEG_OFF;
  - the digit-index width function (clog2 of DIGITS);
  - default scan constants (DIV, BLANK_CYC, BRIGHT_W).
- One sub-module, scan_timer: the slot/digit counters plus the frame_start and last-cycle strobes.
- The display buffer, pending buffer and drive logic stay in the top module.

Test Plan:
- Reset, then hold rst_n=0 → com=8'hFF, seg=8'h00, frame_ready=1, frame_start=0 on every cycle.
- DIGITS=4, SEG_W=8, DIV=4, BLANK_CYC=1, brightness=all-ones, frame=32'hA1B2C3D4 → per slot, 1 cycle blank then 3 cycles lit:
  - com 0111/A1, 1011/B2, 1101/C3, 1110/D4;
  - frame_start high once every 16 cycles.
- Same setup, brightness=3 (BRIGHT_W=3): on_len=floor(3*4/8)=1 → each digit lit for exactly 1 cycle per slot. brightness=0 → on_len=0, all digits dark for the whole slot.
- digit_en=4'b1010 → only digits 1 and 3 light (com 1011 and 1110); the frame period is still 16 cycles.
- Offer frame 32'h11223344 mid-frame → frame_ready falls the next cycle, old data is shown to the end of the frame, the new data appears from the next frame_start, and frame_ready rises after the boundary.
- Assert rst_n=0 during digit 2's lit window → the next cycle shows all-inactive com/seg and a cleared buffer; after release, scanning restarts at digit 0 with frame_start.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed display scanner.
`timescale 1ns/1ps
package display_pkg;

    localparam int DEF_DIV       = 16;
    localparam int DEF_BLANK_CYC = 2;
    localparam int DEF_BRIGHT_W  = 3;

    // Inactive level of a drive line for a given active polarity.
    localparam logic COM_OFF_ACTIVE_LOW  = 1'b1;
    localparam logic COM_OFF_ACTIVE_HIGH = 1'b0;
    localparam logic SEG_OFF_ACTIVE_LOW  = 1'b1;
    localparam logic SEG_OFF_ACTIVE_HIGH = 1'b0;

    function automatic logic off_level(input bit active_low);
        return active_low ? COM_OFF_ACTIVE_LOW : COM_OFF_ACTIVE_HIGH;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// Slot and digit counters for the display scanner, with frame boundary strobes.
`timescale 1ns/1ps
module scan_timer
    import display_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = DEF_DIV
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [idx_w(DIV)-1:0]         slot_cnt,
    output logic [idx_w(DIGITS)-1:0]      digit,
    output logic                          frame_first,
    output logic                          frame_last
);

    localparam int CNT_W = idx_w(DIV);
    localparam int IDX_W = idx_w(DIGITS);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] digit_q, digit_d;

    always_comb begin
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        digit_d    = digit_q;
        if (slot_cnt_q == CNT_W'(DIV - 1)) begin
            slot_cnt_d = '0;
            if (digit_q == IDX_W'(DIGITS - 1)) digit_d = '0;
            else                               digit_d = digit_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
        end
    end

    assign slot_cnt    = slot_cnt_q;
    assign digit       = digit_q;
    assign frame_first = (slot_cnt_q == '0) && (digit_q == '0);
    assign frame_last  = (slot_cnt_q == CNT_W'(DIV - 1)) && (digit_q == IDX_W'(DIGITS - 1));

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed 7-segment / LED-matrix scanner with PWM brightness, anti-ghost
// blanking, per-digit enable and a double-buffered, tear-free frame load.
`timescale 1ns/1ps
module display_scan_mux
    import display_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int SEG_W          = 8,
    parameter int DIV            = DEF_DIV,
    parameter int BLANK_CYC      = DEF_BLANK_CYC,
    parameter int BRIGHT_W       = DEF_BRIGHT_W,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DIGITS*SEG_W-1:0]      frame_data,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic [DIGITS-1:0]            digit_en,
    input  logic [BRIGHT_W-1:0]          brightness,
    output logic [DIGITS-1:0]            com,
    output logic [SEG_W-1:0]             seg,
    output logic                         frame_start,
    output logic [idx_w(DIGITS)-1:0]     digit_idx
);

    localparam int IDX_W    = idx_w(DIGITS);
    localparam int CNT_W    = idx_w(DIV);
    localparam int LIT_SPAN = DIV - BLANK_CYC;
    localparam logic [DIGITS-1:0] COM_OFF = {DIGITS{off_level(COM_ACTIVE_LOW)}};
    localparam logic [SEG_W-1:0]  SEG_OFF = {SEG_W{off_level(SEG_ACTIVE_LOW)}};

    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] digit;
    logic             frame_first, frame_last;

    scan_timer #(
        .DIGITS (DIGITS),
        .DIV    (DIV)
    ) u_scan_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_cnt    (slot_cnt),
        .digit       (digit),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    logic [DIGITS*SEG_W-1:0] disp_q, disp_d, pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic [BRIGHT_W-1:0]     bright_hold_q, bright_hold_d;
    logic [DIGITS-1:0]       en_hold_q, en_hold_d;
    logic [DIGITS-1:0]       com_q, com_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    frame_start_q, frame_start_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

    logic [BRIGHT_W-1:0] bright_eff;
    logic [DIGITS-1:0]   en_eff, sel;
    logic [SEG_W-1:0]    seg_slice;
    logic [31:0]         on_len, slot_ext;
    logic                digit_on, lit;

    always_comb begin
        // Slot-start inputs are used live on cycle 0 and held for the rest of the slot.
        bright_eff    = (slot_cnt == '0) ? brightness : bright_hold_q;
        en_eff        = (slot_cnt == '0) ? digit_en   : en_hold_q;
        bright_hold_d = bright_eff;
        en_hold_d     = en_eff;

        on_len   = (32'(LIT_SPAN) * (32'(bright_eff) + 32'd1)) >> BRIGHT_W;
        slot_ext = 32'(slot_cnt);

        digit_on  = 1'b0;
        seg_slice = '0;
        sel       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit == IDX_W'(i)) begin
                digit_on              = en_eff[i];
                seg_slice             = disp_q[(DIGITS-1-i)*SEG_W +: SEG_W];
                sel[DIGITS-1-i]       = 1'b1;
            end
        end

        lit = digit_on && (slot_ext >= 32'(BLANK_CYC))
                       && ((slot_ext - 32'(BLANK_CYC)) < on_len);

        com_d         = lit ? (COM_OFF ^ sel) : COM_OFF;
        seg_d         = lit ? (SEG_OFF ^ seg_slice) : SEG_OFF;
        frame_start_d = frame_first;
        digit_idx_d   = digit;

        // Pending only reaches the display at the frame boundary, so a frame never tears.
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_last && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (frame_valid && !pend_full_q) begin
            pend_d      = frame_data;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q        <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            bright_hold_q <= '0;
            en_hold_q     <= '0;
            com_q         <= COM_OFF;
            seg_q         <= SEG_OFF;
            frame_start_q <= 1'b0;
            digit_idx_q   <= '0;
        end else begin
            disp_q        <= disp_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            bright_hold_q <= bright_hold_d;
            en_hold_q     <= en_hold_d;
            com_q         <= com_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
            digit_idx_q   <= digit_idx_d;
        end
    end

    assign frame_ready = ~pend_full_q;
    assign com         = com_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;
    assign digit_idx   = digit_idx_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux against a frame-level reference model.
`timescale 1ns/1ps
module tb_display_scan_mux;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 8;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int BW     = 3;
    localparam int FRAME  = DIGITS * DIV;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DIGITS*SEG_W-1:0] frame_data;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [DIGITS-1:0]       digit_en;
    logic [BW-1:0]           brightness;
    logic [DIGITS-1:0]       com;
    logic [SEG_W-1:0]        seg;
    logic                    frame_start;
    logic [1:0]              digit_idx;

    display_scan_mux #(
        .DIGITS(DIGITS), .SEG_W(SEG_W), .DIV(DIV), .BLANK_CYC(BLANK),
        .BRIGHT_W(BW), .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .digit_en(digit_en), .brightness(brightness),
        .com(com), .seg(seg), .frame_start(frame_start), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: absolute position within the frame plus the two buffers.
    int          t = 0;
    logic [7:0]  m_disp [DIGITS];
    logic [7:0]  m_pend [DIGITS];
    bit          m_full = 0;
    int          m_hb = 0;
    logic [3:0]  m_hen = '0;

    logic [3:0]  obs_com;
    logic [7:0]  obs_seg;
    logic        obs_fs, obs_rdy;
    logic [1:0]  obs_idx;
    logic [15:0] obs_v, exp_v;

    task automatic step();
        logic [3:0] e_com;
        logic [7:0] e_seg;
        logic       e_fs, lit, xfer;
        int         slot, dig, onl;
        if (!rst_n) begin
            e_com = 4'hF; e_seg = 8'h00; e_fs = 1'b0; dig = 0;
            for (int i = 0; i < DIGITS; i++) begin m_disp[i] = 8'h00; m_pend[i] = 8'h00; end
            m_full = 0;
            t = 0;
        end else begin
            slot = t % DIV;
            dig  = t / DIV;
            if (slot == 0) begin m_hb = int'(brightness); m_hen = digit_en; end
            onl   = ((DIV - BLANK) * (m_hb + 1)) / (1 << BW);
            lit   = (slot >= BLANK) && (slot - BLANK < onl) && m_hen[dig];
            e_com = lit ? (4'hF ^ (4'b1000 >> dig)) : 4'hF;
            e_seg = lit ? m_disp[dig] : 8'h00;
            e_fs  = (t == 0);
            xfer  = frame_valid && !m_full;
            if (t == FRAME - 1 && m_full) begin
                m_disp = m_pend;
                m_full = 0;
            end
            if (xfer) begin
                for (int i = 0; i < DIGITS; i++) m_pend[i] = frame_data[(DIGITS-1-i)*SEG_W +: SEG_W];
                m_full = 1;
            end
            t = (t + 1) % FRAME;
        end
        exp_v = {e_com, e_seg, e_fs, 2'(dig), ~m_full};
        @(posedge clk);
        @(negedge clk);
        obs_com = com; obs_seg = seg; obs_fs = frame_start; obs_idx = digit_idx; obs_rdy = frame_ready;
        obs_v   = {obs_com, obs_seg, obs_fs, obs_idx, obs_rdy};
    endtask

    task automatic wait_fs(input string name);
        bit seen = 0;
        for (int n = 0; n < 2 * FRAME && !seen; n++) begin
            step();
            vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL %s_model got=%h want=%h", name, obs_v, exp_v); end
            seen = obs_fs;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL %s_fs_timeout got=0 want=1", name); end
    endtask

    task automatic load_frame(input logic [31:0] data);
        wait_fs("load_align");
        for (int n = 0; n < 3; n++) begin
            step();
            vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL load_model got=%h want=%h", obs_v, exp_v); end
        end
        frame_data  = data;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        frame_data  = $urandom;
        vectors++;
        if (obs_rdy !== 1'b0) begin errors++; $display("FAIL load_ready_fall got=%b want=0", obs_rdy); end
        vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL load_model got=%h want=%h", obs_v, exp_v); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            vectors++;
            if ({obs_com, obs_seg, obs_rdy, obs_fs, obs_idx} !== {4'hF, 8'h00, 1'b1, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL reset_hold got com=%h seg=%h rdy=%b fs=%b idx=%0d want com=f seg=00 rdy=1 fs=0 idx=0",
                         obs_com, obs_seg, obs_rdy, obs_fs, obs_idx);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_bright();
        logic [3:0] com_tab [FRAME] = '{4'hF,4'h7,4'h7,4'h7, 4'hF,4'hB,4'hB,4'hB,
                                        4'hF,4'hD,4'hD,4'hD, 4'hF,4'hE,4'hE,4'hE};
        logic [7:0] seg_tab [FRAME] = '{8'h00,8'hA1,8'hA1,8'hA1, 8'h00,8'hB2,8'hB2,8'hB2,
                                        8'h00,8'hC3,8'hC3,8'hC3, 8'h00,8'hD4,8'hD4,8'hD4};
        brightness = 3'd7;
        digit_en   = 4'hF;
        load_frame(32'hA1B2C3D4);
        wait_fs("full_align");
        for (int i = 0; i <= FRAME; i++) begin
            if (i > 0) begin
                step();
                vectors++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL full_model got=%h want=%h", obs_v, exp_v); end
            end
            vectors++;
            if (i < FRAME && ({obs_com, obs_seg, obs_fs} !== {com_tab[i], seg_tab[i], i == 0})) begin
                errors++;
                $display("FAIL full_pattern cyc=%0d got com=%h seg=%h fs=%b want com=%h seg=%h fs=%b",
                         i, obs_com, obs_seg, obs_fs, com_tab[i], seg_tab[i], i == 0);
            end
            if (i == FRAME && obs_fs !== 1'b1) begin
                errors++;
                $display("FAIL full_period got fs=%b want fs=1 after %0d cycles", obs_fs, FRAME);
            end
        end
    endtask

    task automatic run_window(input string name, output int lit_cnt, output int b_cnt,
                              output int e_cnt, output int fs_cnt);
        lit_cnt = 0; b_cnt = 0; e_cnt = 0; fs_cnt = 0;
        for (int n = 0; n < 20 + FRAME; n++) begin
            step();
            vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL %s_model got=%h want=%h", name, obs_v, exp_v); end
            if (n >= 20) begin
                lit_cnt += (obs_com != 4'hF);
                b_cnt   += (obs_com == 4'hB);
                e_cnt   += (obs_com == 4'hE);
                fs_cnt  += obs_fs;
            end
        end
    endtask

    task automatic test_brightness();
        int lc, bc, ec, fc;
        digit_en   = 4'hF;
        brightness = 3'd3;
        run_window("bright3", lc, bc, ec, fc);
        vectors++;
        if (lc !== 4) begin errors++; $display("FAIL bright3_lit_cycles got=%0d want=4", lc); end
        brightness = 3'd0;
        run_window("bright0", lc, bc, ec, fc);
        vectors++;
        if (lc !== 0) begin errors++; $display("FAIL bright0_lit_cycles got=%0d want=0", lc); end
    endtask

    task automatic test_digit_en();
        int lc, bc, ec, fc;
        brightness = 3'd7;
        digit_en   = 4'b1010;
        run_window("den", lc, bc, ec, fc);
        vectors++;
        if ({lc, bc, ec, fc} !== {32'd6, 32'd3, 32'd3, 32'd1}) begin
            errors++;
            $display("FAIL den_pattern got lit=%0d b=%0d e=%0d fs=%0d want lit=6 b=3 e=3 fs=1", lc, bc, ec, fc);
        end
        digit_en = 4'hF;
    endtask

    task automatic test_frame_load();
        brightness = 3'd7;
        digit_en   = 4'hF;
        load_frame(32'h11223344);
        wait_fs("fl_boundary");
        vectors++;
        if (obs_rdy !== 1'b1) begin errors++; $display("FAIL fl_ready_rise got=%b want=1", obs_rdy); end
        step();
        vectors++;
        if ({obs_com, obs_seg} !== {4'h7, 8'h11}) begin
            errors++;
            $display("FAIL fl_new_data got com=%h seg=%h want com=7 seg=11", obs_com, obs_seg);
        end
        vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL fl_model got=%h want=%h", obs_v, exp_v); end
    endtask

    task automatic test_reset_mid();
        int nonzero = 0;
        brightness = 3'd7;
        digit_en   = 4'hF;
        wait_fs("rm_align");
        for (int n = 0; n < 9; n++) begin
            step();
            vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rm_model got=%h want=%h", obs_v, exp_v); end
        end
        vectors++;
        if (obs_com !== 4'hD) begin errors++; $display("FAIL rm_digit2_lit got com=%h want=d", obs_com); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if ({obs_com, obs_seg, obs_rdy} !== {4'hF, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL rm_abort got com=%h seg=%h rdy=%b want com=f seg=00 rdy=1", obs_com, obs_seg, obs_rdy);
        end
        step();
        vectors++;
        if ({obs_fs, obs_idx} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL rm_restart got fs=%b idx=%0d want fs=1 idx=0", obs_fs, obs_idx);
        end
        for (int n = 0; n < FRAME; n++) begin
            step();
            vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rm_model got=%h want=%h", obs_v, exp_v); end
            nonzero += (obs_seg != 8'h00);
        end
        vectors++;
        if (nonzero !== 0) begin errors++; $display("FAIL rm_buffer_cleared got lit_nonzero=%0d want=0", nonzero); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_data  = $urandom;
            if (n % 7 == 0) begin
                brightness = 3'($urandom);
                digit_en   = 4'($urandom);
            end
            rst_n = !(n == 200);
            step();
            vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random_model n=%0d got=%h want=%h", n, obs_v, exp_v); end
        end
        rst_n       = 1'b1;
        frame_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        digit_en    = 4'hF;
        brightness  = 3'd7;
        @(negedge clk);
        test_reset();
        test_full_bright();
        test_brightness();
        test_digit_en();
        test_frame_load();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
